// File: rtl/aes_trigger_ctrl_pkg.sv
// Shared widths and FSM encoding for the AES capture sequencer and its bench.
package aes_trigger_ctrl_pkg;

    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 16;
    localparam int WIN_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_RUN  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/aes_trigger_ctrl_if.sv
// Link between the communication block (master) and the sequencer (slave).
interface aes_trigger_ctrl_if;
    import aes_trigger_ctrl_pkg::*;

    // aes_start is a one-cycle request with pt_to_aes valid in the same cycle; there is no
    // backpressure, a request is taken only while idle and dropped otherwise. aes_ready is a
    // one-cycle completion pulse; ct_from_aes is valid with it and held until the next completion.
    logic               aes_start;
    logic [BLOCK_W-1:0] pt_to_aes;
    logic               aes_ready;
    logic [BLOCK_W-1:0] ct_from_aes;

    modport master (output aes_start, output pt_to_aes, input aes_ready, input ct_from_aes);
    modport slave  (input aes_start, input pt_to_aes, output aes_ready, output ct_from_aes);

endinterface

// File: rtl/aes_trigger_ctrl_window_counter.sv
// Loadable down-counter timing the trigger windows before and after the core runs.
module aes_trigger_ctrl_window_counter
    import aes_trigger_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIN_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/aes_trigger_ctrl.sv
// Sequences one AES operation: pre-trigger window, core run with timeout, post window, ready pulse.
module aes_trigger_ctrl
    import aes_trigger_ctrl_pkg::*;
#(
    parameter int TRIG_PRE  = 4,
    parameter int TRIG_POST = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               reset,
    aes_trigger_ctrl_if.slave  host,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_pt,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_ct,
    output logic               trigger,
    output logic               busy,
    output logic [CNT_W-1:0]   run_cycles,
    output logic               timeout_err,
    output state_t             state_dbg
);

    // The window counter counts down to zero inclusive, so it is loaded with length-1.
    localparam logic [WIN_W-1:0] PRE_LOAD    = WIN_W'(TRIG_PRE - 1);
    localparam logic [WIN_W-1:0] POST_LOAD   = WIN_W'(TRIG_POST - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] core_pt_q, core_pt_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic               tout_q, tout_d;
    logic               core_start_q, core_start_d;
    logic               ready_q, ready_d;
    logic               trigger_q, trigger_d;
    logic               busy_q, busy_d;

    logic               win_load, win_dec, win_zero;
    logic [WIN_W-1:0]   win_load_val;

    aes_trigger_ctrl_window_counter u_window (
        .clk      (clk),
        .reset    (reset),
        .load     (win_load),
        .load_val (win_load_val),
        .dec      (win_dec),
        .zero     (win_zero)
    );

    always_comb begin
        state_d      = state_q;
        core_pt_d    = core_pt_q;
        ct_d         = ct_q;
        run_d        = run_q;
        tout_d       = tout_q;
        core_start_d = 1'b0;
        ready_d      = 1'b0;
        win_load     = 1'b0;
        win_load_val = '0;
        win_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host.aes_start) begin
                    state_d      = ST_PRE;
                    core_pt_d    = host.pt_to_aes;
                    run_d        = '0;
                    tout_d       = 1'b0;
                    win_load     = 1'b1;
                    win_load_val = PRE_LOAD;
                end
            end
            ST_PRE: begin
                if (win_zero) begin
                    state_d      = ST_RUN;
                    core_start_d = 1'b1;
                    run_d        = CNT_W'(1);
                end else begin
                    win_dec = 1'b1;
                end
            end
            ST_RUN: begin
                // core_start_q marks the first RUN cycle, where a done pulse cannot be genuine.
                if (core_done && !core_start_q) begin
                    state_d      = ST_POST;
                    ct_d         = core_ct;
                    win_load     = 1'b1;
                    win_load_val = POST_LOAD;
                end else if (run_q == TIMEOUT_CNT) begin
                    state_d = ST_DONE;
                    tout_d  = 1'b1;
                    ct_d    = '0;
                    ready_d = 1'b1;
                end else if (run_q != '1) begin
                    run_d = run_q + 1'b1;
                end
            end
            ST_POST: begin
                if (win_zero) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                end else begin
                    win_dec = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        trigger_d = (state_d == ST_PRE) || (state_d == ST_RUN) || (state_d == ST_POST);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            core_pt_q    <= '0;
            ct_q         <= '0;
            run_q        <= '0;
            tout_q       <= 1'b0;
            core_start_q <= 1'b0;
            ready_q      <= 1'b0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_pt_q    <= core_pt_d;
            ct_q         <= ct_d;
            run_q        <= run_d;
            tout_q       <= tout_d;
            core_start_q <= core_start_d;
            ready_q      <= ready_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
        end
    end

    assign host.aes_ready   = ready_q;
    assign host.ct_from_aes = ct_q;
    assign core_start       = core_start_q;
    assign core_pt          = core_pt_q;
    assign trigger          = trigger_q;
    assign busy             = busy_q;
    assign run_cycles       = run_q;
    assign timeout_err      = tout_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_aes_trigger_ctrl.sv
// Scoreboard bench for aes_trigger_ctrl with a behavioural AES core responder.
module tb_aes_trigger_ctrl;
    import aes_trigger_ctrl_pkg::*;

    localparam int TRIG_PRE  = 4;
    localparam int TRIG_POST = 4;
    localparam int TIMEOUT   = 20;
    localparam logic [127:0] NOM_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] NOM_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        logic [15:0]  run;
        logic         tout;
        int           trig;
        int           cs_cyc;
        int           rdy_cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         core_start;
    logic [127:0] core_pt;
    logic         core_done;
    logic [127:0] core_ct;
    logic         trigger;
    logic         busy;
    logic [15:0]  run_cycles;
    logic         timeout_err;
    state_t       state_dbg;

    aes_trigger_ctrl_if host ();

    aes_trigger_ctrl #(
        .TRIG_PRE  (TRIG_PRE),
        .TRIG_POST (TRIG_POST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host),
        .core_start  (core_start),
        .core_pt     (core_pt),
        .core_done   (core_done),
        .core_ct     (core_ct),
        .trigger     (trigger),
        .busy        (busy),
        .run_cycles  (run_cycles),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cur_lat = -1;
    bit   cur_early = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [127:0] fake_aes(input logic [127:0] pt);
        if (pt == NOM_PT) return NOM_CT;
        return {pt[63:0], pt[127:64]} ^ {4{32'h9e3779b9}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input int got);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d expected 0", name, got);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_trigger"},     128'(trigger),          128'(0));
        check({tag, "_busy"},        128'(busy),             128'(0));
        check({tag, "_aes_ready"},   128'(host.aes_ready),   128'(0));
        check({tag, "_core_start"},  128'(core_start),       128'(0));
        check({tag, "_ct_from_aes"}, host.ct_from_aes,       128'(0));
        check({tag, "_core_pt"},     core_pt,                128'(0));
        check({tag, "_run_cycles"},  128'(run_cycles),       128'(0));
        check({tag, "_timeout_err"}, 128'(timeout_err),      128'(0));
        check({tag, "_state"},       128'(state_dbg),        128'(ST_IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [127:0] pt, input int lat, input bit early);
        exp_t e;
        int   r;
        @(negedge clk);
        host.aes_start = 1'b1;
        host.pt_to_aes = pt;
        cur_lat   = lat;
        cur_early = early;
        r = early ? 4 : lat + 1;
        e.pt     = pt;
        e.cs_cyc = cyc + TRIG_PRE + 1;
        if (!early && (lat < 0 || r > TIMEOUT)) begin
            e.ct      = '0;
            e.run     = 16'(TIMEOUT);
            e.tout    = 1'b1;
            e.trig    = TRIG_PRE + TIMEOUT;
            e.rdy_cyc = cyc + TRIG_PRE + TIMEOUT + 1;
        end else begin
            e.ct      = fake_aes(pt);
            e.run     = 16'(r);
            e.tout    = 1'b0;
            e.trig    = TRIG_PRE + r + TRIG_POST;
            e.rdy_cyc = cyc + TRIG_PRE + r + TRIG_POST + 1;
        end
        exp_q.push_back(e);
        @(negedge clk);
        host.aes_start = 1'b0;
        host.pt_to_aes = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            report_fail({tag, "_ready_missing"}, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_core_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = core_start;
        end
        if (!seen) report_fail({tag, "_core_start_missing"}, 1);
    endtask

    // ---------------- behavioural AES core ----------------
    initial begin
        int lat;
        bit aborted;
        core_done = 1'b0;
        core_ct   = '0;
        forever begin
            @(negedge clk);
            if (core_start && !reset) begin
                lat     = cur_lat;
                aborted = 1'b0;
                if (cur_early) begin
                    core_done = 1'b1;
                    core_ct   = {$urandom, $urandom, $urandom, $urandom};
                    lat       = 3;
                end
                if (lat < 0 || lat >= TIMEOUT) continue;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    core_done = 1'b0;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    core_done = 1'b1;
                    core_ct   = fake_aes(core_pt);
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   trig_cnt;
        int   cs_cnt;
        exp_t e;
        trig_cnt = 0;
        cs_cnt   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                trig_cnt = 0;
                cs_cnt   = 0;
            end else begin
                if (trigger) trig_cnt++;
                if (core_start) begin
                    cs_cnt++;
                    if (exp_q.size() == 0) begin
                        report_fail("core_start_unexpected", cs_cnt);
                    end else begin
                        check("core_start_cycle", 128'(exp_q[0].cs_cyc == cyc), 128'(1));
                        check("core_pt", core_pt, exp_q[0].pt);
                    end
                end
                if (host.aes_ready) begin
                    if (exp_q.size() == 0) begin
                        report_fail("aes_ready_unexpected", 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("ct_from_aes", host.ct_from_aes, e.ct);
                        check("run_cycles", 128'(run_cycles), 128'(e.run));
                        check("timeout_err", 128'(timeout_err), 128'(e.tout));
                        check("trigger_cycles", 128'(trig_cnt), 128'(e.trig));
                        check("ready_cycle", 128'(cyc), 128'(e.rdy_cyc));
                        check("core_start_count", 128'(cs_cnt), 128'(1));
                        check("trigger_at_ready", 128'(trigger), 128'(0));
                        check("busy_at_ready", 128'(busy), 128'(1));
                    end
                    trig_cnt = 0;
                    cs_cnt   = 0;
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] pt_a;
        logic [127:0] pt_b;
        int           lat;
        reset          = 1'b1;
        host.aes_start = 1'b0;
        host.pt_to_aes = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;

        // nominal block, done 10 cycles after core_start
        issue(NOM_PT, 10, 1'b0);
        wait_done("nominal");

        // core never answers
        issue({$urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
        wait_done("timeout");

        // second start while running must be dropped
        pt_a = {$urandom, $urandom, $urandom, $urandom};
        issue(pt_a, 10, 1'b0);
        wait_core_start("ignored");
        repeat (2) @(negedge clk);
        host.aes_start = 1'b1;
        host.pt_to_aes = '1;
        @(negedge clk);
        host.aes_start = 1'b0;
        @(negedge clk);
        check("ignored_core_pt", core_pt, pt_a);
        wait_done("ignored");

        // done pulse together with core_start, then a real one 3 cycles later
        issue({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        wait_done("early");

        // reset during RUN cycle 5
        issue(NOM_PT, 10, 1'b0);
        wait_core_start("midrun");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_cleared("midrun");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(NOM_PT, 10, 1'b0);
        wait_done("after_reset");

        // back-to-back: second start on the first IDLE cycle
        pt_a = {$urandom, $urandom, $urandom, $urandom};
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        issue(pt_a, 6, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host.aes_ready) break;
        end
        issue(pt_b, 8, 1'b0);
        wait_core_start("b2b");
        check("b2b_ct_held", host.ct_from_aes, fake_aes(pt_a));
        wait_done("b2b");

        // randomized traffic
        for (int n = 0; n < 20; n++) begin
            lat = $urandom_range(1, 24);
            if (lat >= TIMEOUT) lat = -1;
            issue({$urandom, $urandom, $urandom, $urandom}, lat, ($urandom_range(0, 5) == 0));
            wait_done("random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_trigger_ctrl.md
# aes_trigger_ctrl

Sequencer between the UART communication block and the AES core in the side-channel capture design. Accepts a plaintext block and start pulse from the communication block, brackets the encryption with a scope trigger window, launches the core, and returns the ciphertext with a one-cycle ready pulse. Also provides a cycle count of the encryption and a timeout flag, so that captures from a hung core are never mistaken for valid traces.

## Interface
Parameters:
- TRIG_PRE, 4: cycles trigger is high before core_start; legal range 1..255.
- TRIG_POST, 4: cycles trigger stays high after core_done; legal range 1..255.
- TIMEOUT, 1023: maximum RUN cycles before abort; legal range 2..65535.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- aes_start  in  1  one-cycle pulse; pt_to_aes is valid in the same cycle.
- pt_to_aes  in  128  plaintext from the communication block.
- aes_ready  out  1  one-cycle pulse; ct_from_aes is valid.
- ct_from_aes  out  128  ciphertext; held until the next completion.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_pt  out  128  latched plaintext to the core; stable from PRE through DONE.
- core_done  in  1  core completion pulse.
- core_ct  in  128  core ciphertext, valid with core_done.
- trigger  out  1  oscilloscope trigger.
- busy  out  1  high in every state except IDLE.
- run_cycles  out  16  RUN-state cycle count of the last operation.
- timeout_err  out  1  high when the last operation timed out.

## Operation
- FSM states: IDLE, PRE, RUN, POST, DONE.
- IDLE to PRE on aes_start:
  - latch pt_to_aes into core_pt;
  - clear run_cycles and timeout_err.
- PRE:
  - trigger=1;
  - down-counter runs for TRIG_PRE cycles, then the FSM moves to RUN.
- RUN:
  - core_start=1 in the first RUN cycle only;
  - run_cycles increments every RUN cycle, starting at 1 in the first cycle;
  - core_done is ignored in the first RUN cycle;
  - on core_done, latch core_ct into ct_from_aes and go to POST;
  - if run_cycles reaches TIMEOUT with no core_done, go to DONE with timeout_err=1 and ct_from_aes=0.
- POST: trigger=1 for TRIG_POST cycles, then go to DONE.
- DONE:
  - aes_ready=1 for one cycle;
  - trigger=0;
  - next state is IDLE.
- aes_start outside IDLE is ignored; no queuing.
- core_done outside RUN is ignored.
- run_cycles saturates at 16'hFFFF; it cannot exceed TIMEOUT anyway.
- Reset values: state=IDLE; all outputs 0, including ct_from_aes, core_pt, run_cycles and timeout_err.
- Reset mid-operation: return to IDLE immediately; no aes_ready is issued; trigger drops on the next edge.

## Timing
- All outputs are registered.
- aes_start high in cycle N:
  - trigger=1 and busy=1 in cycles N+1..N+TRIG_PRE;
  - core_start=1 in cycle N+TRIG_PRE+1.
- core_done high in cycle M:
  - ct_from_aes updates at M+1;
  - trigger stays high through M+TRIG_POST;
  - aes_ready=1 in cycle M+TRIG_POST+1;
  - busy=0 from M+TRIG_POST+2.
- Earliest next accepted aes_start is the first IDLE cycle, i.e. M+TRIG_POST+2.
- Timeout: aes_ready is in the cycle after the RUN cycle where run_cycles==TIMEOUT.

## Structure
- Shared header aes_sca_defs.vh holds:
  - BLOCK_W=128, CNT_W=16;
  - state encodings (IDLE=0, PRE=1, RUN=2, POST=3, DONE=4), also used by bench monitors.
- One natural sub-module: aes_window_counter.
  - Loadable 8-bit down-counter with a zero flag.
  - Instantiated once and shared by PRE and POST.
  - The run counter stays in the top level.

## Test plan
- Nominal: pt 00112233445566778899aabbccddeeff; behavioural core returns 69c4e0d86a7b0430d8cdb78070b4c55a with core_done 10 cycles after core_start. Required: trigger high 4+11+4 cycles, aes_ready once, run_cycles=11, timeout_err=0.
- Timeout: TIMEOUT=20, core never asserts core_done. Required: aes_ready at cycle 20 of RUN, ct_from_aes=0, timeout_err=1, run_cycles=20, no POST trigger.
- Ignored start: second aes_start with pt ffff…ff during RUN. Required: core_pt unchanged, exactly one aes_ready, no second core_start.
- Early done: core_done asserted together with core_start and again 3 cycles later. Required: the first is ignored, run_cycles=4.
- Reset mid-RUN: reset in RUN cycle 5. Required: next cycle all outputs 0 and state IDLE, no aes_ready; a following nominal run completes correctly.
- Back-to-back: aes_start on the first IDLE cycle after aes_ready. Required: it is accepted, and ct_from_aes keeps the first result until the second completion.
